// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI command sequencer.
package sd_pkg;

    localparam int unsigned FRAME_W = 48;

    localparam logic [7:0] SD_FILL   = 8'hFF;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic       STOP_BIT  = 1'b1;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_POLL   = 3'd4,
        S_TAIL   = 3'd5,
        S_FINISH = 3'd6
    } sd_state_e;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
    } sd_cmd_t;

    // Full 48-bit command frame, first byte in the top bits.
    function automatic logic [FRAME_W-1:0] sd_frame(input sd_cmd_t cmd);
        return {CMD_START, cmd.idx, cmd.arg, cmd.crc, STOP_BIT};
    endfunction

endpackage

// File: rtl/sd_cmd_seq_if.sv
// Host-side command/response and SPI byte-engine signals of the sequencer.
interface sd_cmd_seq_if;
    logic        init_stb;
    logic        cmd_stb;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        busy;
    logic        resp_stb;
    logic [7:0]  resp_r1;
    logic        resp_to;
    logic        cs_n;
    logic        w_stb;
    logic [7:0]  w_data;
    logic        w_ack;
    logic        r_stb;
    logic [7:0]  r_data;

    // Environment view: card-driver FSM plus byte engine.
    modport master (
        output init_stb, cmd_stb, cmd_idx, cmd_arg, cmd_crc, w_ack, r_stb, r_data,
        input  busy, resp_stb, resp_r1, resp_to, cs_n, w_stb, w_data
    );

    // Sequencer view.
    modport slave (
        input  init_stb, cmd_stb, cmd_idx, cmd_arg, cmd_crc, w_ack, r_stb, r_data,
        output busy, resp_stb, resp_r1, resp_to, cs_n, w_stb, w_data
    );
endinterface

// File: rtl/sd_byte_issuer.sv
// Issues one byte strobe per go and reports the engine's W_ACK rising edge.
module sd_byte_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    input  logic       w_ack,
    output logic       w_stb,
    output logic [7:0] w_data,
    output logic       done
);
    logic       ack_q, ack_d;
    logic       wait_q, wait_d;
    logic       stb_q, stb_d;
    logic       done_q, done_d;
    logic [7:0] data_q, data_d;

    // Edges of W_ACK outside a pending byte are ignored.
    always_comb begin
        ack_d  = w_ack;
        stb_d  = 1'b0;
        done_d = 1'b0;
        data_d = data_q;
        wait_d = wait_q;
        if (go) begin
            stb_d  = 1'b1;
            data_d = data;
            wait_d = 1'b1;
        end else if (wait_q && w_ack && !ack_q) begin
            wait_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            wait_q <= 1'b0;
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= 8'hFF;
        end else begin
            ack_q  <= ack_d;
            wait_q <= wait_d;
            stb_q  <= stb_d;
            done_q <= done_d;
            data_q <= data_d;
        end
    end

    assign w_stb  = stb_q;
    assign w_data = data_q;
    assign done   = done_q;

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI command sequencer: init dummy clocks, 6-byte command frame, R1 poll, CS release.
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int unsigned INIT_BYTES = 10,
    parameter int unsigned NCR_MAX    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sd_cmd_seq_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    sd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               resp_stb_q, resp_stb_d;
    logic [7:0]         resp_r1_q, resp_r1_d;
    logic               resp_to_q, resp_to_d;
    logic               cs_n_q, cs_n_d;

    logic               go_c;
    logic [7:0]         go_data_c;
    logic               ready_c;
    logic [CNT_W-1:0]   poll_c;
    sd_cmd_t            cmd_c;
    logic               done;

    sd_byte_issuer u_issuer (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go_c),
        .data   (go_data_c),
        .w_ack  (bus.w_ack),
        .w_stb  (bus.w_stb),
        .w_data (bus.w_data),
        .done   (done)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        busy_d     = busy_q;
        resp_stb_d = 1'b0;
        resp_r1_d  = resp_r1_q;
        resp_to_d  = resp_to_q;
        cs_n_d     = cs_n_q;
        go_c       = 1'b0;
        go_data_c  = SD_FILL;
        poll_c     = cnt_q;
        cmd_c.idx  = bus.cmd_idx;
        cmd_c.arg  = bus.cmd_arg;
        cmd_c.crc  = bus.cmd_crc;
        // A new byte may go out in the same cycle the previous one completes.
        ready_c    = !inflight_q || done;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                if (bus.init_stb) begin
                    state_d   = S_INIT;
                    cnt_d     = CNT_W'(INIT_BYTES);
                    busy_d    = 1'b1;
                    resp_to_d = 1'b0;
                end else if (bus.cmd_stb) begin
                    state_d   = S_LOAD;
                    frame_d   = sd_frame(cmd_c);
                    busy_d    = 1'b1;
                    resp_to_d = 1'b0;
                end
            end
            S_INIT: begin
                cs_n_d = 1'b1;
                if (ready_c) begin
                    if (cnt_q == '0) begin
                        state_d    = S_FINISH;
                        resp_r1_d  = SD_FILL;
                        resp_to_d  = 1'b0;
                        resp_stb_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        go_c  = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cs_n_d  = 1'b0;
                cnt_d   = CNT_W'(6);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (ready_c) begin
                    if (cnt_q == '0) begin
                        state_d = S_POLL;
                    end else begin
                        go_c      = 1'b1;
                        go_data_c = frame_q[FRAME_W-1 -: 8];
                        frame_d   = {frame_q[FRAME_W-9:0], SD_FILL};
                        cnt_d     = cnt_q - 1'b1;
                    end
                end
            end
            S_POLL: begin
                // A valid R1 beats a timeout landing in the same cycle.
                if (bus.r_stb && !bus.r_data[7]) begin
                    resp_r1_d = bus.r_data;
                    resp_to_d = 1'b0;
                    cnt_d     = CNT_W'(1);
                    state_d   = S_TAIL;
                end else if (ready_c) begin
                    poll_c = (done && cnt_q != CNT_SAT) ? cnt_q + 1'b1 : cnt_q;
                    cnt_d  = poll_c;
                    if (poll_c >= CNT_W'(NCR_MAX)) begin
                        resp_r1_d = SD_FILL;
                        resp_to_d = 1'b1;
                        cnt_d     = CNT_W'(1);
                        state_d   = S_TAIL;
                    end else begin
                        go_c = 1'b1;
                    end
                end
            end
            S_TAIL: begin
                // Wait out the in-flight poll byte, then release CS for one fill byte.
                if (ready_c) begin
                    cs_n_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d    = S_FINISH;
                        resp_stb_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        go_c  = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = go_c ? 1'b1 : (done ? 1'b0 : inflight_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            resp_stb_q <= 1'b0;
            resp_r1_q  <= SD_FILL;
            resp_to_q  <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            resp_stb_q <= resp_stb_d;
            resp_r1_q  <= resp_r1_d;
            resp_to_q  <= resp_to_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.resp_stb = resp_stb_q;
    assign bus.resp_r1  = resp_r1_q;
    assign bus.resp_to  = resp_to_q;
    assign bus.cs_n     = cs_n_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Scoreboard bench for sd_cmd_seq with a byte-engine model acking each byte after 8 clocks.
module tb_sd_cmd_seq;
    localparam int ACK_DLY = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sd_cmd_seq_if bus ();

    sd_cmd_seq #(.INIT_BYTES(10), .NCR_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_bytes[$];   // {cs_n, w_data}
    logic [8:0] exp_resp[$];    // {resp_r1, resp_to}

    int         resp_at  = 0;   // frame-relative byte whose ack carries R_STB (0 = none)
    logic [7:0] resp_val = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic cs, input logic [63:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bytes.push_back({cs, bytes[i*8 +: 8]});
    endtask

    task automatic push_fill(input logic cs, input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back({cs, 8'hFF});
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
        @(posedge clk); #1;
        bus.cmd_idx = idx; bus.cmd_arg = arg; bus.cmd_crc = crc; bus.cmd_stb = 1'b1;
        @(posedge clk); #1;
        bus.cmd_stb = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.resp_stb) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no RESP_STB within %0d cycles", name, bound);
        end
        @(negedge clk);
        check({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    endtask

    // Byte engine: ack each byte after ACK_DLY clocks; optionally deliver R_STB with that ack.
    initial begin
        int byte_no = 0;
        bus.w_ack = 1'b0; bus.r_stb = 1'b0; bus.r_data = 8'hFF;
        forever begin
            @(posedge clk); #1;
            if (bus.cs_n) byte_no = 0;
            if (bus.w_stb) begin
                if (!bus.cs_n) byte_no++;
                repeat (ACK_DLY) @(posedge clk);
                #1;
                bus.w_ack = 1'b1;
                if (resp_at > 0 && byte_no == resp_at) begin
                    bus.r_stb = 1'b1; bus.r_data = resp_val;
                end
                @(posedge clk); #1;
                bus.w_ack = 1'b0; bus.r_stb = 1'b0; bus.r_data = 8'hFF;
            end
        end
    end

    // Monitor: compare every issued byte and every response against the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.w_stb) begin
                    if (exp_bytes.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_byte: got cs_n=%b data=%h expected none", bus.cs_n, bus.w_data);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("byte", {23'd0, bus.cs_n, bus.w_data}, {23'd0, e});
                    end
                end
                if (bus.resp_stb) begin
                    if (exp_resp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_resp: got r1=%h to=%b expected none", bus.resp_r1, bus.resp_to);
                    end else begin
                        e = exp_resp.pop_front();
                        check("resp_r1", 32'(bus.resp_r1), 32'(e[8:1]));
                        check("resp_to", 32'(bus.resp_to), 32'(e[0]));
                        check("busy_at_resp", 32'(bus.busy), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

    initial begin
        int nstb;
        rst_n = 1'b0;
        bus.init_stb = 1'b0; bus.cmd_stb = 1'b0;
        bus.cmd_idx = '0; bus.cmd_arg = '0; bus.cmd_crc = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_cs_n",     32'(bus.cs_n),     32'd1);
        check("rst_w_stb",    32'(bus.w_stb),    32'd0);
        check("rst_w_data",   32'(bus.w_data),   32'hFF);
        check("rst_resp_r1",  32'(bus.resp_r1),  32'hFF);
        check("rst_resp_to",  32'(bus.resp_to),  32'd0);
        check("rst_resp_stb", 32'(bus.resp_stb), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Init burst: ten fill bytes with CS high.
        push_fill(1'b1, 10);
        exp_resp.push_back({8'hFF, 1'b0});
        @(posedge clk); #1; bus.init_stb = 1'b1;
        @(posedge clk); #1; bus.init_stb = 1'b0;
        wait_resp("init", 400);
        check("init_busy_after", 32'(bus.busy), 32'd0);

        // CMD0 with R1=0x01 on the second poll byte.
        resp_at = 8; resp_val = 8'h01;
        push_seq(1'b0, 64'h40_00_00_00_00_95_FF_FF, 8);
        push_fill(1'b1, 1);
        exp_resp.push_back({8'h01, 1'b0});
        send_cmd(6'd0, 32'h0, 7'h4A);
        wait_resp("cmd0", 400);
        check("cmd0_cs_n_after", 32'(bus.cs_n), 32'd1);

        // CMD8 with no response: eight polls then timeout.
        resp_at = 0;
        push_seq(1'b0, 64'h00_00_48_00_00_01_AA_87, 6);
        push_fill(1'b0, 8);
        push_fill(1'b1, 1);
        exp_resp.push_back({8'hFF, 1'b1});
        send_cmd(6'd8, 32'h0000_01AA, 7'h43);
        wait_resp("cmd8", 600);
        repeat (5) @(negedge clk);
        check("hold_resp_r1", 32'(bus.resp_r1), 32'hFF);
        check("hold_resp_to", 32'(bus.resp_to), 32'd1);

        // Strobes while busy are dropped; R_STB=0x00 during SEND is not captured.
        resp_at = 2; resp_val = 8'h00;
        push_seq(1'b0, 64'h00_00_40_00_00_00_00_95, 6);
        push_fill(1'b0, 8);
        push_fill(1'b1, 1);
        exp_resp.push_back({8'hFF, 1'b1});
        send_cmd(6'd0, 32'h0, 7'h4A);
        @(negedge clk);
        check("accept_clears_to", 32'(bus.resp_to), 32'd0);
        check("accept_busy", 32'(bus.busy), 32'd1);
        repeat (20) @(posedge clk);
        #1; bus.cmd_stb = 1'b1; bus.init_stb = 1'b1; bus.cmd_idx = 6'd17;
        @(posedge clk); #1; bus.cmd_stb = 1'b0; bus.init_stb = 1'b0;
        wait_resp("busy_drop", 600);

        // Reset while the third frame byte is in flight.
        resp_at = 0;
        push_seq(1'b0, 64'h00_00_00_00_00_77_00_00, 3);
        send_cmd(6'd55, 32'h0, 7'h32);
        nstb = 0;
        for (int i = 0; i < 300 && nstb < 3; i++) begin
            @(negedge clk);
            if (bus.w_stb) nstb++;
        end
        check("rst_mid_reached_byte3", 32'(nstb), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n",  32'(bus.cs_n),  32'd1);
        check("rst_mid_w_stb", 32'(bus.w_stb), 32'd0);
        check("rst_mid_busy",  32'(bus.busy),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("rst_mid_idle_busy", 32'(bus.busy), 32'd0);

        // Clean CMD17 after reset, R1=0x00 on the first poll byte.
        resp_at = 7; resp_val = 8'h00;
        push_seq(1'b0, 64'h00_51_00_00_12_34_55_FF, 7);
        push_fill(1'b1, 1);
        exp_resp.push_back({8'h00, 1'b0});
        send_cmd(6'd17, 32'h0000_1234, 7'h2A);
        wait_resp("cmd17", 400);

        // ACMD41: response rides the final poll byte's ack.
        resp_at = 14; resp_val = 8'h05;
        push_seq(1'b0, 64'h00_00_69_40_00_00_00_E5, 6);
        push_fill(1'b0, 8);
        push_fill(1'b1, 1);
        exp_resp.push_back({8'h05, 1'b0});
        send_cmd(6'd41, 32'h4000_0000, 7'h72);
        wait_resp("acmd41", 600);

        repeat (20) @(negedge clk);
        check("resp_left", 32'(exp_resp.size()), 32'd0);
        check("final_cs_n", 32'(bus.cs_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_seq.md
Name: sd_cmd_seq

Overview:
Command sequencer for the SD-card SPI byte engine. It issues the power-up dummy-clock burst and frames 6-byte SD commands as byte strobes to the engine. It then polls with 0xFF fill bytes until an R1 response arrives or the poll budget expires. It sits between the card-driver top-level FSM and the SPI byte controller, and it owns chip select.

Parameters:
INIT_BYTES, 10, number of 0xFF bytes sent with CS_N high during init (10 bytes = 80 clocks)
NCR_MAX, 8, maximum 0xFF poll bytes after the command before timeout (1..255)

Ports:
CLK  in  1  system clock, same clock as the byte engine
RST_N  in  1  asynchronous active-low reset
INIT_STB  in  1  one-cycle pulse: run the init dummy-clock burst
CMD_STB  in  1  one-cycle pulse: send a command
CMD_IDX  in  6  command index
CMD_ARG  in  32  command argument
CMD_CRC  in  7  CRC7 of the frame, supplied by the caller
BUSY  out  1  high from the accepted strobe until the DONE state exits
RESP_STB  out  1  one-cycle pulse: response valid or timeout
RESP_R1  out  8  captured R1 byte; 0xFF on timeout
RESP_TO  out  1  qualifies RESP_STB: 1 = timeout
CS_N  out  1  card chip select, active low
W_STB  out  1  byte-write strobe to the engine
W_DATA  out  8  byte to transmit
W_ACK  in  1  engine finished the current byte (level, held ≥1 cycle)
R_STB  in  1  engine received a byte (pulse)
R_DATA  in  8  received byte

Behaviour:
- Reset values, asynchronous on RST_N low: state IDLE, BUSY=0, RESP_STB=0, RESP_R1=0xFF, RESP_TO=0, CS_N=1, W_STB=0, W_DATA=0xFF, all counters 0.
- Reset mid-operation aborts immediately. No trailing byte is sent.
- Byte handshake: in the cycle a byte is issued, W_STB=1 for exactly one cycle with W_DATA valid. The FSM then waits for the rising edge of W_ACK, detected against a registered copy of W_ACK. It issues no new W_STB until that edge. W_ACK edges seen outside a wait are ignored.
- States:
  - IDLE: CS_N=1.
    - INIT_STB → INIT, byte counter = INIT_BYTES.
    - Else CMD_STB → LOAD. LOAD latches IDX, ARG and CRC into a 48-bit shift register {2'b01, IDX, ARG, CRC, 1'b1}.
    - If INIT_STB and CMD_STB arrive together, INIT wins and CMD_STB is dropped.
    - Strobes that arrive while BUSY=1 are ignored.
  - INIT: CS_N=1. Send 0xFF bytes until the counter reaches 0, then → FINISH with no response. FINISH pulses RESP_STB with RESP_TO=0 and RESP_R1=0xFF.
  - LOAD: one cycle. CS_N drops to 0 here and stays low through SEND and POLL. → SEND.
  - SEND: send the 6 frame bytes MSB-first. Byte 0 = 0x40|IDX; byte 5 = {CRC,1}. After the 6th W_ACK edge → POLL, poll counter = 0. Any R_STB during SEND is discarded.
  - POLL: send 0xFF bytes.
    - R_STB with R_DATA[7]=0 → capture RESP_R1=R_DATA and go to TAIL. The byte in flight completes first; TAIL waits for its W_ACK edge.
    - R_STB with R_DATA[7]=1 is ignored.
    - Each W_ACK edge increments the poll counter. When it reaches NCR_MAX with no response, set RESP_R1=0xFF and RESP_TO=1 → TAIL.
    - If R_STB and the final W_ACK edge arrive in the same cycle, the response wins and RESP_TO=0.
  - TAIL: set CS_N=1, then send one 0xFF byte for the 8-clock release → FINISH.
  - FINISH: RESP_STB=1 for one cycle, BUSY drops in the same cycle → IDLE.
    - RESP_R1 and RESP_TO hold until the next accepted strobe.
    - Accepting a new strobe clears RESP_TO to 0.
- Frame-to-response latency: 6 + n + 1 byte-times, where n is the number of poll bytes. Up to 2 extra cycles of FSM overhead per byte are allowed.
- Counters are 8 bits wide and saturate; they never wrap.

Decomposition:
- Shared package sd_pkg: state encoding constants, SD_FILL=8'hFF, CMD_START=2'b01, STOP_BIT=1'b1, and command-index constants CMD0, CMD8, CMD55, ACMD41 and CMD17.
- One natural sub-module: sd_byte_issuer. It wraps the W_STB pulse and the W_ACK edge-detect, with ports go, data, done. The sequencer FSM instantiates it.

Test Plan:
- INIT_STB with the engine model acking every byte after 8 clocks → exactly 10 bytes of 0xFF with CS_N=1 throughout, then RESP_STB with RESP_TO=0 and BUSY low.
- CMD_STB with IDX=0, ARG=0, CRC=0x4A; model returns 0x01 on the 2nd poll byte → W_DATA sequence 40 00 00 00 00 95 FF FF, then one FF with CS_N=1. RESP_R1=0x01, RESP_TO=0, CS_N low only from LOAD to TAIL.
- CMD_STB with IDX=8, ARG=0x000001AA, CRC=0x43 and no response → 6 frame bytes (48 00 00 01 AA 87), then exactly NCR_MAX=8 poll bytes, then RESP_TO=1 and RESP_R1=0xFF.
- CMD_STB pulsed again while BUSY, and R_STB=0x00 injected during SEND → second command not started; the SEND-phase byte is not captured.
- RST_N dropped during the 3rd frame byte → CS_N=1, W_STB=0 and BUSY=0 immediately. A following CMD_STB runs a full, clean frame.
- Final poll W_ACK edge and R_STB (R_DATA=0x05) in the same cycle → RESP_R1=0x05, RESP_TO=0.
